// File: rtl/reorder_pkg.sv
// reorder_pkg: shared types and defaults for the packet reorder buffer blocks
package reorder_pkg;
  typedef enum logic [1:0] {IDLE, FWD, DROP} fwd_state_t;
  localparam int DEF_TAG_WIDTH = 6;
  localparam int DEF_CIRCULAR_BUFFER_SIZE = 50;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_MAX_TDATA_PER_PACKET = 256;
  localparam logic [1:0] PKT_ACCEPT = 2'b11;
  localparam logic [1:0] PKT_REJECT = 2'b01;
endpackage

// File: rtl/axis_out_reg.sv
// axis_out_reg: one-deep valid/ready holding register; a new load wins over a drain
module axis_out_reg #(
  parameter int WIDTH = 71
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] payload,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             free
);
  assign free = !valid || ready;
  // hold the beat until the consumer takes it; reload directly when a new beat arrives
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= payload;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/reorder_tag_forwarder.sv
// reorder_tag_forwarder: tags incoming packets with wrapping reorder tags and forwards beats, truncating oversize packets
module reorder_tag_forwarder
  import reorder_pkg::*;
#(
  parameter int TAG_WIDTH            = DEF_TAG_WIDTH,
  parameter int CIRCULAR_BUFFER_SIZE = DEF_CIRCULAR_BUFFER_SIZE,
  parameter int DATA_WIDTH           = DEF_DATA_WIDTH,
  parameter int MAX_TDATA_PER_PACKET = DEF_MAX_TDATA_PER_PACKET
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_TDATA,
  input  logic                  s_TLAST,
  input  logic                  s_TVALID,
  output logic                  s_TREADY,
  input  logic                  fwd_rdy,
  output logic [DATA_WIDTH-1:0] buffer_TDATA,
  output logic [TAG_WIDTH-1:0]  reorder_tag,
  output logic                  buffer_TLAST,
  output logic                  buffer_TVALID,
  input  logic                  buffer_TREADY,
  output logic                  tag_alloc_valid,
  output logic [TAG_WIDTH-1:0]  tag_alloc,
  output logic [15:0]           trunc_count
);
  localparam int CNT_W = $clog2(MAX_TDATA_PER_PACKET) + 1;
  localparam int PW = DATA_WIDTH + TAG_WIDTH + 1;
  fwd_state_t state;
  logic [TAG_WIDTH-1:0] next_tag;
  logic [TAG_WIDTH-1:0] tag_inc;
  logic [CNT_W-1:0] beat_cnt;
  logic out_free;
  logic accept;
  logic load;
  logic trunc;
  logic last_out;
  // s_TREADY is held low while reset is asserted, even though fwd_rdy may be high
  assign s_TREADY = rst && (state == IDLE ? fwd_rdy && out_free : state == FWD ? out_free : 1'b1);
  assign accept   = s_TVALID && s_TREADY;
  assign load     = accept && state != DROP;
  assign trunc    = state == FWD && accept && !s_TLAST && beat_cnt == CNT_W'(MAX_TDATA_PER_PACKET - 1);
  assign last_out = s_TLAST || trunc;
  assign tag_inc  = next_tag == TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1) ? '0 : next_tag + 1'b1;
  axis_out_reg #(.WIDTH(PW)) u_obuf (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .payload ({s_TDATA, next_tag, last_out}),
    .ready   (buffer_TREADY),
    .data    ({buffer_TDATA, reorder_tag, buffer_TLAST}),
    .valid   (buffer_TVALID),
    .free    (out_free)
  );
  // packet FSM, tag issue, beat counting and truncation statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      next_tag        <= '0;
      beat_cnt        <= '0;
      trunc_count     <= '0;
      tag_alloc_valid <= 1'b0;
      tag_alloc       <= '0;
    end else begin
      tag_alloc_valid <= accept && state == IDLE;
      if (accept && state == IDLE) tag_alloc <= next_tag;
      if (load && last_out) next_tag <= tag_inc;
      if (trunc && trunc_count != 16'hFFFF) trunc_count <= trunc_count + 1'b1;
      if (accept) begin
        beat_cnt <= state == IDLE ? CNT_W'(1) : state == FWD ? beat_cnt + 1'b1 : beat_cnt;
        state    <= s_TLAST ? IDLE : state == IDLE ? FWD : (trunc || state == DROP) ? DROP : FWD;
      end
    end
  end
endmodule
